decstage_pipe: RTL and testbench
================================

Name: decstage_pipe

Overview:
- Parametrised pipelined decode stage for the MIPS datapath.
- Decodes the instruction fields, reads the register file, and builds the immediate in one of four extension modes.
- Latches results into an ID/EX output register under a valid/ready handshake.
- Adds write-back bypass, a one-cycle load-use bubble, and flush; sits between IFSTAGE and EXSTAGE.

Parameters:
- DATA_W, 32: register/datapath width; must be >= 32.
- R0_ZERO, 1: 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is an ordinary register.

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- In_valid  in  1  Instr is valid this cycle
- In_ready  out  1  stage accepts Instr this cycle
- Instr  in  32  MIPS instruction word
- Instr_is_load  in  1  Instr is a load (from control)
- Rt_used  in  1  Instr reads rt as a source (from control)
- RF_B_sel  in  1  0: read port 2 address = Instr[15:11]; 1: Instr[20:16]
- Immed_mode  in  2  00 sign-ext, 01 zero-ext, 10 imm<<16, 11 sign-ext<<2
- RF_WrEn  in  1  write-back enable
- RF_WrAddr  in  5  write-back address
- ALU_out  in  DATA_W  write-back candidate 0
- MEM_out  in  DATA_W  write-back candidate 1
- RF_WrData_sel  in  1  0: write ALU_out; 1: write MEM_out
- Flush  in  1  kill contents of the output register
- Out_valid  out  1  ID/EX register holds a valid instruction
- Out_ready  in  1  EXSTAGE consumes the output this cycle
- RF_A  out  DATA_W  registered read port 1 data
- RF_B  out  DATA_W  registered read port 2 data
- Immed  out  DATA_W  registered extended immediate
- Out_rt  out  5  registered Instr[20:16], load destination
- Out_is_load  out  1  registered Instr_is_load
- Hazard  out  1  load-use bubble being inserted this cycle

Behaviour:
- Register file:
  - 32 x DATA_W, two combinational read ports, one write port.
  - Read port 1 address = Instr[25:21].
  - Read port 2 address = Instr[15:11] or Instr[20:16], selected by RF_B_sel.
  - Write on the rising edge when RF_WrEn = 1; data WrData = RF_WrData_sel ? MEM_out : ALU_out.
  - With R0_ZERO = 1, writes to address 0 are dropped and reads of address 0 return 0.
- Write-back bypass:
  - If RF_WrEn = 1 and RF_WrAddr equals a read address (and is nonzero when R0_ZERO = 1), that port returns WrData in the same cycle.
- Immediate: imm = Instr[15:0], extended to DATA_W.
  - Mode 00: sign-extended.
  - Mode 01: zero-extended.
  - Mode 10: {imm, 16'b0}, zero-extended above bit 31.
  - Mode 11: sign-extended, then shifted left by 2; the top 2 bits are discarded.
- Hazard (combinational):
  - Hazard = Out_valid & Out_is_load & (Out_rt != 0) & In_valid & (Out_rt == Instr[25:21] | (Rt_used & Out_rt == Instr[20:16])).
  - The compare against 0 is skipped when R0_ZERO = 0.
- Handshake:
  - advance = ~Out_valid | Out_ready.
  - In_ready = advance & ~Hazard.
  - Input transfer occurs when In_valid & In_ready.
- ID/EX register update, in priority order:
  1. Reset: Out_valid, RF_A, RF_B, Immed, Out_rt, Out_is_load all 0; register file cleared to 0.
  2. Flush: Out_valid <= 0; data fields are don't-care. Flush beats a simultaneous transfer, and the input is not consumed (In_ready = 0 while Flush = 1).
  3. advance & Hazard: insert a bubble. Out_valid <= 0; the input instruction is held. Next cycle Out_is_load = 0, so Hazard clears and the instruction issues. The bubble is exactly one cycle.
  4. Input transfer: capture all fields; Out_valid <= 1.
  5. advance & ~In_valid: Out_valid <= 0.
  6. Otherwise (Out_valid & ~Out_ready): hold every output unchanged.
- Held data and the register file:
  - While the output is stalled, later write-backs still update the register file.
  - Held RF_A/RF_B are not refreshed; EX forwarding covers that case.
- Latency: one cycle from input transfer to Out_valid.
- Throughput: one instruction per cycle when there are no hazards or stalls.
- Reset mid-operation: the pipeline empties on the next edge, and In_ready = 1 on the cycle after Reset deasserts.

Test Plan:
1. Reset, then write reg5 = 0x1234 and reg6 = 0xFFFF0000 via RF_WrEn; issue an add with rs = 5, rt = 6, rd = 7 and RF_B_sel = 1 -> one cycle later Out_valid = 1, RF_A = 0x1234, RF_B = 0xFFFF0000.
2. Imm = 0x8001 in each Immed_mode -> Immed = 0xFFFF8001, 0x00008001, 0x80010000, 0xFFFE0004.
3. Same-cycle write-back of reg3 = 0xA5A5A5A5 while decoding rs = 3; also write reg0 = 0xDEAD and read rs = 0 with R0_ZERO = 1 -> RF_A = 0xA5A5A5A5; the reg0 read returns 0.
4. Load with rt = 4 issued, followed immediately by an instruction with rs = 4 -> Hazard = 1 and In_ready = 0 for exactly one cycle; Out_valid shows a 0 bubble; the dependent instruction issues next cycle with no instruction lost.
5. Out_ready = 0 for 3 cycles with Out_valid = 1 -> outputs stable, In_ready = 0; on release, back-to-back instructions stream one per cycle.
6. Flush asserted together with In_valid, then Reset pulsed mid-stream -> Out_valid = 0 next cycle and the instruction is not consumed; after Reset all outputs and register-file reads are 0.

Source files
------------

// File: rtl/decstage_pipe_if.sv
// Decode-stage bundle: upstream instruction handshake, write-back port and ID/EX outputs.
// The slave modport is the decode stage; the master modport is the surrounding pipeline.
interface decstage_pipe_if #(
   parameter int DATA_W = 32
);
   logic              In_valid;
   logic              In_ready;
   logic [31:0]       Instr;
   logic              Instr_is_load;
   logic              Rt_used;
   logic              RF_B_sel;
   logic [1:0]        Immed_mode;
   logic              RF_WrEn;
   logic [4:0]        RF_WrAddr;
   logic [DATA_W-1:0] ALU_out;
   logic [DATA_W-1:0] MEM_out;
   logic              RF_WrData_sel;
   logic              Flush;
   logic              Out_valid;
   logic              Out_ready;
   logic [DATA_W-1:0] RF_A;
   logic [DATA_W-1:0] RF_B;
   logic [DATA_W-1:0] Immed;
   logic [4:0]        Out_rt;
   logic              Out_is_load;
   logic              Hazard;

   modport master (
      output In_valid, Instr, Instr_is_load, Rt_used, RF_B_sel, Immed_mode,
             RF_WrEn, RF_WrAddr, ALU_out, MEM_out, RF_WrData_sel, Flush, Out_ready,
      input  In_ready, Out_valid, RF_A, RF_B, Immed, Out_rt, Out_is_load, Hazard
   );

   modport slave (
      input  In_valid, Instr, Instr_is_load, Rt_used, RF_B_sel, Immed_mode,
             RF_WrEn, RF_WrAddr, ALU_out, MEM_out, RF_WrData_sel, Flush, Out_ready,
      output In_ready, Out_valid, RF_A, RF_B, Immed, Out_rt, Out_is_load, Hazard
   );
endinterface

// File: rtl/decstage_pipe.sv
// MIPS decode stage: field decode, 2R1W register file with write-back bypass, immediate extension.
// One cycle into the ID/EX register; stalls while Out_ready is low, one-cycle bubble on load-use.
module decstage_pipe #(
   parameter int DATA_W  = 32,
   parameter int R0_ZERO = 1
) (
   input  logic           Clk,
   input  logic           Reset,
   decstage_pipe_if.slave bus
);
   logic [DATA_W-1:0] rf [32];

   logic [4:0]        rs_f;
   logic [4:0]        rt_f;
   logic [4:0]        rd_f;
   logic [4:0]        rb_addr;
   logic [15:0]       imm;
   logic [5:0]        opcode_unused;

   logic [DATA_W-1:0] wr_data;
   logic              wr_ok;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic [DATA_W-1:0] imm_sx;
   logic [DATA_W-1:0] imm_zx;
   logic [DATA_W-1:0] imm_ext;

   logic              hazard;
   logic              rt_nonzero;
   logic              advance;
   logic              take;

   logic              out_valid_q;
   logic              out_is_load_q;
   logic [4:0]        out_rt_q;
   logic [DATA_W-1:0] rf_a_q;
   logic [DATA_W-1:0] rf_b_q;
   logic [DATA_W-1:0] immed_q;

   assign rs_f    = bus.Instr[25:21];
   assign rt_f    = bus.Instr[20:16];
   assign rd_f    = bus.Instr[15:11];
   assign imm     = bus.Instr[15:0];
   assign rb_addr = bus.RF_B_sel ? rt_f : rd_f;

   // The opcode is decoded by the control unit, not here.
   assign opcode_unused = bus.Instr[31:26];

   assign wr_data = bus.RF_WrData_sel ? bus.MEM_out : bus.ALU_out;
   assign wr_ok   = bus.RF_WrEn && !((R0_ZERO != 0) && (bus.RF_WrAddr == 5'd0));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) begin
            rf[i] <= '0;
         end
      end else if (wr_ok) begin
         rf[bus.RF_WrAddr] <= wr_data;
      end
   end

   always_comb begin
      rd_a = rf[rs_f];
      if (wr_ok && (bus.RF_WrAddr == rs_f)) begin
         rd_a = wr_data;
      end
      if ((R0_ZERO != 0) && (rs_f == 5'd0)) begin
         rd_a = '0;
      end
   end

   always_comb begin
      rd_b = rf[rb_addr];
      if (wr_ok && (bus.RF_WrAddr == rb_addr)) begin
         rd_b = wr_data;
      end
      if ((R0_ZERO != 0) && (rb_addr == 5'd0)) begin
         rd_b = '0;
      end
   end

   assign imm_sx = {{(DATA_W-16){imm[15]}}, imm};
   assign imm_zx = {{(DATA_W-16){1'b0}}, imm};

   always_comb begin
      case (bus.Immed_mode)
         2'b00:   imm_ext = imm_sx;
         2'b01:   imm_ext = imm_zx;
         2'b10:   imm_ext = imm_zx << 16;
         default: imm_ext = imm_sx << 2;
      endcase
   end

   // A load into r0 never produces a real dependency when r0 is hardwired.
   assign rt_nonzero = (R0_ZERO == 0) || (out_rt_q != 5'd0);
   assign hazard     = out_valid_q && out_is_load_q && rt_nonzero && bus.In_valid &&
                       ((out_rt_q == rs_f) || (bus.Rt_used && (out_rt_q == rt_f)));

   assign advance = !out_valid_q || bus.Out_ready;
   assign take    = bus.In_valid && advance && !hazard && !bus.Flush;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         out_valid_q   <= 1'b0;
         out_is_load_q <= 1'b0;
         out_rt_q      <= '0;
         rf_a_q        <= '0;
         rf_b_q        <= '0;
         immed_q       <= '0;
      end else if (bus.Flush) begin
         out_valid_q   <= 1'b0;
         out_is_load_q <= 1'b0;
      end else if (take) begin
         out_valid_q   <= 1'b1;
         out_is_load_q <= bus.Instr_is_load;
         out_rt_q      <= rt_f;
         rf_a_q        <= rd_a;
         rf_b_q        <= rd_b;
         immed_q       <= imm_ext;
      end else if (advance) begin
         // Covers both the load-use bubble and an empty input slot.
         out_valid_q   <= 1'b0;
         out_is_load_q <= 1'b0;
      end
   end

   assign bus.In_ready    = advance && !hazard && !bus.Flush;
   assign bus.Hazard      = hazard;
   assign bus.Out_valid   = out_valid_q;
   assign bus.Out_is_load = out_is_load_q;
   assign bus.Out_rt      = out_rt_q;
   assign bus.RF_A        = rf_a_q;
   assign bus.RF_B        = rf_b_q;
   assign bus.Immed       = immed_q;
endmodule

// File: tb/tb_decstage_pipe.sv
// Bench for decstage_pipe: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the decode stage.
module tb_decstage_pipe;
   localparam int DW = 32;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   decstage_pipe_if #(.DATA_W(DW)) bus ();

   decstage_pipe #(.DATA_W(DW), .R0_ZERO(1)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_rf [32];
   logic        m_valid;
   logic        m_load;
   logic [4:0]  m_rt;
   logic [31:0] m_a;
   logic [31:0] m_b;
   logic [31:0] m_imm;
   bit          chk_en = 0;

   function automatic logic [31:0] m_wdata();
      return bus.RF_WrData_sel ? bus.MEM_out : bus.ALU_out;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (bus.RF_WrEn && bus.RF_WrAddr == a) return m_wdata();
      return m_rf[a];
   endfunction

   function automatic logic [31:0] m_immed(input logic [15:0] v, input logic [1:0] mode);
      int          s;
      int unsigned u;
      s = $signed(v);
      u = v;
      case (mode)
         2'd0:    return s;
         2'd1:    return u;
         2'd2:    return u * 65536;
         default: return s * 4;
      endcase
   endfunction

   function automatic logic m_hazard();
      logic [4:0] rs;
      logic [4:0] rt;
      rs = bus.Instr[25:21];
      rt = bus.Instr[20:16];
      return m_valid && m_load && (m_rt != 0) && bus.In_valid &&
             ((m_rt == rs) || (bus.Rt_used && (m_rt == rt)));
   endfunction

   function automatic logic m_ready();
      return (!m_valid || bus.Out_ready) && !m_hazard() && !bus.Flush;
   endfunction

   always @(posedge Clk) begin
      if (Reset) begin
         foreach (m_rf[i]) m_rf[i] = 32'd0;
         m_valid = 0; m_load = 0; m_rt = 0; m_a = 0; m_b = 0; m_imm = 0;
         chk_en  = 1;
      end else begin
         if (bus.Flush) begin
            m_valid = 0;
         end else if (bus.In_valid && m_ready()) begin
            m_valid = 1;
            m_a     = m_read(bus.Instr[25:21]);
            m_b     = m_read(bus.RF_B_sel ? bus.Instr[20:16] : bus.Instr[15:11]);
            m_imm   = m_immed(bus.Instr[15:0], bus.Immed_mode);
            m_rt    = bus.Instr[20:16];
            m_load  = bus.Instr_is_load;
         end else if (!m_valid || bus.Out_ready) begin
            m_valid = 0;
         end
         if (bus.RF_WrEn && bus.RF_WrAddr != 5'd0) m_rf[bus.RF_WrAddr] = m_wdata();
      end
   end

   always @(negedge Clk) begin
      if (chk_en) begin
         chk("cyc_in_ready", 32'(bus.In_ready), 32'(m_ready()));
         chk("cyc_hazard", 32'(bus.Hazard), 32'(m_hazard()));
         chk("cyc_out_valid", 32'(bus.Out_valid), 32'(m_valid));
         if (m_valid) begin
            chk("cyc_rf_a", bus.RF_A, m_a);
            chk("cyc_rf_b", bus.RF_B, m_b);
            chk("cyc_immed", bus.Immed, m_imm);
            chk("cyc_out_rt", 32'(bus.Out_rt), 32'(m_rt));
            chk("cyc_is_load", 32'(bus.Out_is_load), 32'(m_load));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [31:0] ins, input logic ld,
                         input logic rtu, input logic bsel, input logic [1:0] mode);
      bus.In_valid      = v;
      bus.Instr         = ins;
      bus.Instr_is_load = ld;
      bus.Rt_used       = rtu;
      bus.RF_B_sel      = bsel;
      bus.Immed_mode    = mode;
   endtask

   task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] alu,
                         input logic [31:0] mem, input logic sel);
      bus.RF_WrEn       = en;
      bus.RF_WrAddr     = a;
      bus.ALU_out       = alu;
      bus.MEM_out       = mem;
      bus.RF_WrData_sel = sel;
   endtask

   function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
      return {6'd0, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   logic [31:0] imm_exp [4];
   logic [31:0] rnd_ins;
   logic        fire;

   initial begin
      imm_exp[0] = 32'hFFFF8001;
      imm_exp[1] = 32'h00008001;
      imm_exp[2] = 32'h80010000;
      imm_exp[3] = 32'hFFFE0004;

      Reset         = 1'b1;
      bus.Out_ready = 1'b1;
      bus.Flush     = 1'b0;
      set_in(0, 32'd0, 0, 0, 0, 2'd0);
      set_wb(0, 5'd0, 32'd0, 32'd0, 0);
      tick();
      tick();
      Reset = 1'b0;
      #1;
      chk("rst_out_valid", 32'(bus.Out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.In_ready), 32'd1);

      // Register writes, then an add reading both.
      set_wb(1, 5'd5, 32'h0000_1234, 32'd0, 0);
      tick();
      set_wb(1, 5'd6, 32'd0, 32'hFFFF_0000, 1);
      tick();
      set_wb(0, 5'd0, 32'd0, 32'd0, 0);
      set_in(1, r_ins(5'd5, 5'd6, 5'd7), 0, 1, 1, 2'd0);
      tick();
      set_in(0, 32'd0, 0, 0, 0, 2'd0);
      chk("add_out_valid", 32'(bus.Out_valid), 32'd1);
      chk("add_rf_a", bus.RF_A, 32'h0000_1234);
      chk("add_rf_b", bus.RF_B, 32'hFFFF_0000);

      // Immediate 0x8001 in every extension mode.
      for (int m = 0; m < 4; m++) begin
         set_in(1, i_ins(6'h08, 5'd0, 5'd1, 16'h8001), 0, 0, 1, 2'(m));
         tick();
         chk("imm_mode", bus.Immed, imm_exp[m]);
      end

      // Same-cycle bypass, then a write to r0 that must be ignored.
      set_wb(1, 5'd3, 32'hA5A5_A5A5, 32'd0, 0);
      set_in(1, r_ins(5'd3, 5'd0, 5'd9), 0, 1, 1, 2'd0);
      tick();
      chk("byp_rf_a", bus.RF_A, 32'hA5A5_A5A5);
      chk("byp_rf_b_r0", bus.RF_B, 32'd0);
      set_wb(1, 5'd0, 32'h0000_DEAD, 32'd0, 0);
      set_in(1, r_ins(5'd0, 5'd3, 5'd0), 0, 1, 1, 2'd0);
      tick();
      chk("r0_byp_rf_a", bus.RF_A, 32'd0);
      chk("r3_stored_rf_b", bus.RF_B, 32'hA5A5_A5A5);
      set_wb(0, 5'd0, 32'd0, 32'd0, 0);
      set_in(1, r_ins(5'd0, 5'd0, 5'd0), 0, 1, 1, 2'd0);
      tick();
      chk("r0_read_rf_a", bus.RF_A, 32'd0);

      // Load rt=4 followed by a consumer of r4.
      set_in(1, i_ins(6'h23, 5'd1, 5'd4, 16'd0), 1, 0, 1, 2'd0);
      tick();
      chk("ld_out_rt", 32'(bus.Out_rt), 32'd4);
      chk("ld_is_load", 32'(bus.Out_is_load), 32'd1);
      set_in(1, r_ins(5'd4, 5'd2, 5'd8), 0, 1, 1, 2'd0);
      #1;
      chk("lu_hazard", 32'(bus.Hazard), 32'd1);
      chk("lu_in_ready", 32'(bus.In_ready), 32'd0);
      tick();
      chk("lu_bubble", 32'(bus.Out_valid), 32'd0);
      #1;
      chk("lu_hazard_clear", 32'(bus.Hazard), 32'd0);
      chk("lu_in_ready_back", 32'(bus.In_ready), 32'd1);
      tick();
      chk("lu_issue_valid", 32'(bus.Out_valid), 32'd1);
      chk("lu_issue_rt", 32'(bus.Out_rt), 32'd2);

      // Three-cycle output stall, then streaming.
      set_in(1, r_ins(5'd5, 5'd6, 5'd10), 0, 1, 1, 2'd0);
      tick();
      bus.Out_ready = 1'b0;
      set_in(1, r_ins(5'd6, 5'd5, 5'd11), 0, 1, 1, 2'd0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_in_ready", 32'(bus.In_ready), 32'd0);
         tick();
         chk("stall_valid", 32'(bus.Out_valid), 32'd1);
         chk("stall_rf_a", bus.RF_A, 32'h0000_1234);
      end
      bus.Out_ready = 1'b1;
      #1;
      chk("release_in_ready", 32'(bus.In_ready), 32'd1);
      tick();
      chk("release_rf_a", bus.RF_A, 32'hFFFF_0000);
      chk("release_rt", 32'(bus.Out_rt), 32'd5);
      for (int k = 1; k <= 3; k++) begin
         set_in(1, r_ins(5'(k), 5'(k), 5'd0), 0, 1, 1, 2'd0);
         #1;
         chk("stream_in_ready", 32'(bus.In_ready), 32'd1);
         tick();
         chk("stream_valid", 32'(bus.Out_valid), 32'd1);
         chk("stream_rt", 32'(bus.Out_rt), 32'(k));
      end

      // Flush against a presented instruction, then a reset mid-stream.
      set_in(1, r_ins(5'd1, 5'd2, 5'd3), 0, 1, 1, 2'd0);
      bus.Flush = 1'b1;
      #1;
      chk("flush_in_ready", 32'(bus.In_ready), 32'd0);
      tick();
      chk("flush_valid", 32'(bus.Out_valid), 32'd0);
      bus.Flush = 1'b0;
      tick();
      chk("after_flush_valid", 32'(bus.Out_valid), 32'd1);
      chk("after_flush_rt", 32'(bus.Out_rt), 32'd2);
      set_in(1, r_ins(5'd5, 5'd6, 5'd4), 1, 1, 1, 2'd0);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      set_in(0, 32'd0, 0, 0, 0, 2'd0);
      chk("mid_rst_valid", 32'(bus.Out_valid), 32'd0);
      chk("mid_rst_rf_a", bus.RF_A, 32'd0);
      chk("mid_rst_rf_b", bus.RF_B, 32'd0);
      chk("mid_rst_immed", bus.Immed, 32'd0);
      chk("mid_rst_rt", 32'(bus.Out_rt), 32'd0);
      chk("mid_rst_is_load", 32'(bus.Out_is_load), 32'd0);
      #1;
      chk("mid_rst_in_ready", 32'(bus.In_ready), 32'd1);
      set_in(1, r_ins(5'd5, 5'd6, 5'd0), 0, 1, 1, 2'd0);
      tick();
      chk("rf_cleared_a", bus.RF_A, 32'd0);
      chk("rf_cleared_b", bus.RF_B, 32'd0);
      set_in(0, 32'd0, 0, 0, 0, 2'd0);
      tick();

      // Randomized traffic; upstream holds its instruction until it is accepted.
      fire = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!bus.In_valid || fire) begin
            rnd_ins          = $urandom;
            rnd_ins[25:21]   = 5'($urandom_range(0, 7));
            rnd_ins[20:16]   = 5'($urandom_range(0, 7));
            rnd_ins[15:11]   = 5'($urandom_range(0, 7));
            set_in(1'($urandom_range(0, 9) < 8), rnd_ins, 1'($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)));
         end
         set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                1'($urandom_range(0, 1)));
         bus.Out_ready = ($urandom_range(0, 3) != 0);
         bus.Flush     = ($urandom_range(0, 15) == 0);
         Reset         = ($urandom_range(0, 299) == 0);
         @(negedge Clk);
         fire = bus.In_valid && bus.In_ready;
         tick();
      end

      Reset     = 1'b0;
      bus.Flush = 1'b0;
      set_in(0, 32'd0, 0, 0, 0, 2'd0);
      set_wb(0, 5'd0, 32'd0, 32'd0, 0);
      tick();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
